// File: rtl/seven_seg_arbiter.sv
// Owns the board's 4-digit seven-segment display: fixed-priority arbitration between
// three requesters with a minimum hold time, digit scan, BCD decode and blanking.
module seven_seg_arbiter #(
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_CYCLES = 25000000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  grant,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] OPEN = 2'd2;

  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [1:0]        state, state_nx;
  logic [2:0]        grant_nx, winner;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
  logic              rearb;
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit_idx;
  logic [15:0]       owner_data;
  logic [3:0]        nibble;
  logic              blank;
  logic [6:0]        pattern;

  always_comb begin
    winner = 3'b000;
    if (req[0])      winner = 3'b001;
    else if (req[1]) winner = 3'b010;
    else if (req[2]) winner = 3'b100;
  end

  // In OPEN the holder keeps the display only while it is still the best requester;
  // a different winner means either preemption or the holder has let go.
  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    hold_cnt_nx = hold_cnt;
    rearb       = 1'b0;
    case (state)
      IDLE: rearb = 1'b1;
      HOLD: begin
        if ((req & grant) == 3'b000)
          rearb = 1'b1;
        else if (hold_cnt == '0)
          state_nx = OPEN;
        else
          hold_cnt_nx = hold_cnt - HOLD_W'(1);
      end
      OPEN:    rearb = (winner != grant);
      default: rearb = 1'b1;
    endcase
    if (rearb) begin
      grant_nx    = winner;
      hold_cnt_nx = (winner == 3'b000) ? '0 : HOLD_LOAD;
      state_nx    = (winner == 3'b000) ? IDLE : HOLD;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      grant    <= 3'b000;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      hold_cnt <= hold_cnt_nx;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // A digit is blanked only when it and everything to its left is zero; digit 0 always shows.
  always_comb begin
    owner_data = 16'h0000;
    if (grant[0])      owner_data = data0;
    else if (grant[1]) owner_data = data1;
    else if (grant[2]) owner_data = data2;
    case (digit_idx)
      2'd0: begin
        nibble = owner_data[3:0];
        blank  = 1'b0;
      end
      2'd1: begin
        nibble = owner_data[7:4];
        blank  = (owner_data[15:4] == 12'h000);
      end
      2'd2: begin
        nibble = owner_data[11:8];
        blank  = (owner_data[15:8] == 8'h00);
      end
      default: begin
        nibble = owner_data[15:12];
        blank  = (owner_data[15:12] == 4'h0);
      end
    endcase
  end

  always_comb begin
    pattern = 7'b1111111;
    if (!blank) begin
      case (nibble)
        4'd0:    pattern = 7'b1000000;
        4'd1:    pattern = 7'b1111001;
        4'd2:    pattern = 7'b0100100;
        4'd3:    pattern = 7'b0110000;
        4'd4:    pattern = 7'b0011001;
        4'd5:    pattern = 7'b0010010;
        4'd6:    pattern = 7'b0000010;
        4'd7:    pattern = 7'b1111000;
        4'd8:    pattern = 7'b0000000;
        4'd9:    pattern = 7'b0010000;
        default: pattern = 7'b1111111;
      endcase
    end
  end

  // an and seg are registered together so the pins never show one digit's anode with another's segments.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else if (grant == 3'b000) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      an  <= ~(4'b0001 << digit_idx);
      seg <= pattern;
    end
  end

  assign dp = 1'b1;

endmodule

// File: doc/seven_seg_arbiter.md
# seven_seg_arbiter

Shares the board's 4-digit seven-segment display between three independent requesters, such as the game-state, score and debug blocks. It arbitrates ownership with fixed priority and a minimum hold time, and time-multiplexes the four anodes at a programmable scan rate. It decodes the owner's four BCD nibbles with leading-zero blanking and drives `an`/`seg`/`dp` to the top-level pins. It replaces ad-hoc per-feature display drivers: only this block touches the display pins.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); legal ≥ 2.
- `HOLD_CYCLES`, default 25000000: minimum grant duration in cycles (0.25 s); legal ≥ 2.
- `clock`  in  1  system clock; all state on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req`  in  3  per-requester display request; `req[0]` has highest priority, `req[2]` lowest.
- `data0`, `data1`, `data2`  in  16 each  four BCD nibbles per requester; `[15:12]` is the leftmost digit, `[3:0]` the rightmost.
- `grant`  out  3  one-hot owner; 3'b000 when idle.
- `an`  out  4  anodes, active-low; `an[0]` is the rightmost digit.
- `seg`  out  7  `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal point, active-low; held 1 (off) always.

## Operation
- FSM states:
  - IDLE: no grant.
  - HOLD: grant valid, hold counter running.
  - OPEN: grant valid, hold expired.
- IDLE transitions:
  - Any `req` bit set: grant the highest-priority set bit, load hold counter = HOLD_CYCLES−1, go to HOLD.
  - Otherwise stay in IDLE.
- HOLD transitions, evaluated in priority order:
  - Holder's `req` low: re-arbitrate immediately, as in IDLE. If no `req`, go to IDLE; otherwise grant the new winner and reload the counter.
  - Counter = 0: go to OPEN; grant unchanged.
  - Otherwise decrement the counter. Higher-priority requests are ignored.
- OPEN transitions:
  - Any `req` set whose priority is higher than the holder's: grant it, reload the counter, go to HOLD.
  - Holder's `req` low: re-arbitrate as in IDLE.
  - Otherwise stay in OPEN; the holder keeps the display.
- Scan:
  - Scan counter counts 0..SCAN_DIV−1 and wraps.
  - On wrap, digit index advances 0→1→2→3→0.
  - The scan runs in every state and is never reset by grant changes.
- Decode of the selected nibble (grantee's data, nibble = digit index):
  - 0–9 use standard patterns, e.g. 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - 10–15 are blank (7'b1111111).
- Leading-zero blanking:
  - Digit i > 0 is blanked when nibbles i..3 are all zero.
  - Digit 0 is always shown, so value 0000 displays a single "0".
- Output register, updated every cycle:
  - `an` = ~(1 << index) while granted; 4'b1111 in IDLE.
  - `seg` = decoded pattern while granted; 7'b1111111 in IDLE.
  - `dp` = 1.
  - `an` and `seg` always come from the same cycle's index and data, so they never mismatch.

## Timing
- Reset values, asserted asynchronously:
  - State IDLE; `grant` = 0.
  - `an` = 4'b1111, `seg` = 7'b1111111, `dp` = 1.
  - Scan counter = 0, digit index = 0, hold counter = 0.
- Reset mid-grant: outputs blank immediately (asynchronous). After `resetn` rises, the first arbitration happens on the first clock edge with `req` set.
- Grant latency:
  - `req` seen at edge N yields `grant` valid after edge N.
  - `an`/`seg` reflect the new owner after edge N+1 (one registered stage).
- Data latency: a change in the grantee's data appears on `an`/`seg` one cycle later, provided its digit is currently selected.
- Minimum hold: a grant issued at edge N cannot be preempted before edge N+HOLD_CYCLES. It can still be released early by the holder dropping `req`.
- Simultaneous events:
  - Holder drop and higher-priority request in the same cycle: the higher-priority requester is granted that edge.
  - Several new requests at once: the lowest index wins.
- Digit index changes on the edge where the scan counter wraps SCAN_DIV−1→0.

## Test plan
(Bench uses SCAN_DIV=4, HOLD_CYCLES=8.)
- Reset: hold `resetn`=0 for 5 cycles with `req`=3'b111 -> `grant`=0, `an`=4'b1111, `seg`=7'b1111111, `dp`=1. Release `resetn` -> `grant`=3'b001 one edge later.
- Scan and blanking: `req`=3'b001, `data0`=16'h0042 -> `an` cycles 1110, 1101, 1011, 0111, each held 4 cycles. `seg` shows 2 (7'b0100100), then 4 (7'b0011001), then blank, then blank; nibble 4'hA is blank; `data0`=0 shows only "0" on `an[0]`.
- Hold protection: `req`=3'b100 granted, then `req[0]` rises 2 cycles later -> `grant` stays 3'b100 until 8 cycles after the original grant, then becomes 3'b001 on the following edge.
- Early release: `req[1]` granted, drop `req[1]` at cycle 3 with `req[2]`=1 -> `grant`=3'b100 on the next edge and the hold counter reloads. Drop all `req` -> IDLE, `an`=4'b1111 one cycle later.
- OPEN retention: `req[1]` held past expiry with `req[2]` asserted -> `grant` stays 3'b010 indefinitely. Assert `req[0]` -> 3'b001 next edge.
- Simultaneous: holder drops `req` in the same cycle `req[0]` and `req[2]` rise -> `grant`=3'b001.
